// File: rtl/dcache_pkg.sv
// Shared geometry, FSM state type and address-field helpers for the L1 data cache.
package dcache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BLK_BITS   = 256;
  localparam int unsigned OFF_W      = 5;
  localparam int unsigned WORD_IDX_W = 3;
  localparam int unsigned LINES      = 32;
  localparam int unsigned IDX_W      = $clog2(LINES);
  localparam int unsigned TAG_W      = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_ALLOCATE
  } state_e;

  // Helpers return right-justified fields so a caller with any index width can narrow them.
  function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                 input int unsigned idx_w);
    return addr >> (OFF_W + idx_w);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] addr,
                                                   input int unsigned idx_w);
    return (addr >> OFF_W) & ((ADDR_W'(1) << idx_w) - ADDR_W'(1));
  endfunction

  function automatic logic [WORD_IDX_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W-1:2];
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Line storage: tag and data arrays plus per-line valid/dirty bits that clear on reset.
module dcache_sram import dcache_pkg::*; #(
  parameter int unsigned N_LINES   = 32,
  parameter int unsigned IDX_BITS  = 5,
  parameter int unsigned TAG_BITS  = 22,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX_BITS-1:0]   idx_i,
  output logic                  valid_o,
  output logic                  dirty_o,
  output logic [TAG_BITS-1:0]   tag_o,
  output logic [LINE_BITS-1:0]  line_o,
  input  logic                  line_we_i,
  input  logic [TAG_BITS-1:0]   line_tag_i,
  input  logic [LINE_BITS-1:0]  line_data_i,
  input  logic                  word_we_i,
  input  logic [WORD_IDX_W-1:0] word_sel_i,
  input  logic [WORD_W-1:0]     word_data_i,
  input  logic                  clr_dirty_i
);

  logic [N_LINES-1:0]   valid_q;
  logic [N_LINES-1:0]   dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [N_LINES];
  logic [LINE_BITS-1:0] data_q [N_LINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

  // Refill leaves the line clean; a store hit marks it dirty; a finished writeback cleans it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end else if (clr_dirty_i) begin
      dirty_q[idx_i] <= 1'b0;
    end
  end

  // Tag/data arrays carry no reset so they can map onto plain memory macros.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[idx_i]  <= line_tag_i;
      data_q[idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_q[idx_i][WORD_W*word_sel_i +: WORD_W] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 data cache: hit path, miss FSM and memory port.
module dcache_ctrl #(
  parameter int unsigned LINES    = 32,
  parameter int unsigned BLK_BITS = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         cpu_addr_i,
  input  logic                cpu_rd_i,
  input  logic                cpu_wr_i,
  input  logic [31:0]         cpu_wdata_i,
  output logic [31:0]         cpu_rdata_o,
  output logic                stall_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [31:0]         mem_addr_o,
  output logic [BLK_BITS-1:0] mem_wdata_o,
  input  logic [BLK_BITS-1:0] mem_rdata_i,
  input  logic                mem_ack_i
);
  import dcache_pkg::*;

  localparam int unsigned IDX_BITS = $clog2(LINES);
  localparam int unsigned TAG_BITS = ADDR_W - IDX_BITS - OFF_W;

  state_e                state_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [31:0]           mem_addr_q;
  logic [BLK_BITS-1:0]   mem_wdata_q;

  logic [TAG_BITS-1:0]   cpu_tag;
  logic [IDX_BITS-1:0]   cpu_idx;
  logic [WORD_IDX_W-1:0] cpu_word;
  logic [31:0]           cpu_line_addr;
  logic [31:0]           vic_line_addr;
  logic                  vic_valid;
  logic                  vic_dirty;
  logic [TAG_BITS-1:0]   vic_tag;
  logic [BLK_BITS-1:0]   line_rd;
  logic                  access;
  logic                  hit;
  logic                  miss;
  logic                  store_we;
  logic                  refill_we;
  logic                  wb_done;

  assign cpu_tag       = TAG_BITS'(addr_tag(cpu_addr_i, IDX_BITS));
  assign cpu_idx       = IDX_BITS'(addr_index(cpu_addr_i, IDX_BITS));
  assign cpu_word      = addr_word(cpu_addr_i);
  assign cpu_line_addr = {cpu_tag, cpu_idx, {OFF_W{1'b0}}};
  assign vic_line_addr = {vic_tag, cpu_idx, {OFF_W{1'b0}}};

  assign access    = cpu_rd_i | cpu_wr_i;
  assign hit       = access & vic_valid & (vic_tag == cpu_tag);
  assign miss      = access & ~hit;
  assign store_we  = (state_q == ST_IDLE) & cpu_wr_i & hit;
  assign refill_we = (state_q == ST_ALLOCATE) & mem_ack_i;
  assign wb_done   = (state_q == ST_WRITEBACK) & mem_ack_i;

  dcache_sram #(
    .N_LINES  (LINES),
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS),
    .LINE_BITS(BLK_BITS)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (cpu_idx),
    .valid_o     (vic_valid),
    .dirty_o     (vic_dirty),
    .tag_o       (vic_tag),
    .line_o      (line_rd),
    .line_we_i   (refill_we),
    .line_tag_i  (cpu_tag),
    .line_data_i (mem_rdata_i),
    .word_we_i   (store_we),
    .word_sel_i  (cpu_word),
    .word_data_i (cpu_wdata_i),
    .clr_dirty_i (wb_done)
  );

  // Stall is gated by reset so an abandoned miss releases the pipeline immediately.
  assign stall_o     = rst_i & ((state_q != ST_IDLE) | miss);
  assign cpu_rdata_o = line_rd[WORD_W*cpu_word +: WORD_W];

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  // Miss FSM with registered memory-port outputs held stable for the whole request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (miss) begin
            mem_req_q <= 1'b1;
            if (vic_valid && vic_dirty) begin
              state_q     <= ST_WRITEBACK;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= vic_line_addr;
              mem_wdata_q <= line_rd;
            end else begin
              state_q    <= ST_ALLOCATE;
              mem_we_q   <= 1'b0;
              mem_addr_q <= cpu_line_addr;
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ack_i) begin
            state_q    <= ST_ALLOCATE;
            mem_we_q   <= 1'b0;
            mem_addr_q <= cpu_line_addr;
          end
        end
        ST_ALLOCATE: begin
          if (mem_ack_i) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios plus random traffic checked against a flat-memory reference.
`timescale 1ns/1ps
module tb_dcache_ctrl;

  localparam int BUDGET = 64;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic         cpu_rd_i = 1'b0;
  logic         cpu_wr_i = 1'b0;
  logic [31:0]  cpu_wdata_i = '0;
  logic [31:0]  cpu_rdata_o;
  logic         stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i = '0;
  logic         mem_ack_i = 1'b0;

  dcache_ctrl #(.LINES(32), .BLK_BITS(256)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_rd_i(cpu_rd_i), .cpu_wr_i(cpu_wr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } req_t;

  // Off-chip memory (line granular) and the CPU-visible flat memory view.
  logic [255:0] offchip [logic [31:0]];
  logic [31:0]  flat    [logic [31:0]];
  bit           mv [32];
  bit           md [32];
  logic [21:0]  mt [32];
  req_t         exp_q[$];
  req_t         req_log[$];

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    logic [31:0] la;
    la = {wa[31:5], 5'b0};
    if (la == 32'h40) return 32'hA0 + 32'(wa[4:2]);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [255:0] offchip_line(input logic [31:0] la);
    logic [255:0] l;
    if (offchip.exists(la)) return offchip[la];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word(la + 32'(4*w));
    return l;
  endfunction

  function automatic logic [31:0] flat_word(input logic [31:0] a);
    logic [31:0]  key;
    logic [255:0] l;
    key = {a[31:2], 2'b00};
    if (flat.exists(key)) return flat[key];
    l = offchip_line({a[31:5], 5'b0});
    return l[32*a[4:2] +: 32];
  endfunction

  function automatic logic [255:0] flat_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = flat_word(la + 32'(4*w));
    return l;
  endfunction

  // Memory responder: acks a request after lat+1 visible cycles, logs it, flags unstable outputs.
  int           lat = 2;
  int           cnt = 0;
  bit           unstable = 0;
  logic         prev_req = 1'b0;
  logic         prev_we;
  logic [31:0]  prev_addr;
  logic [255:0] prev_wdata;
  req_t         mem_r;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      mem_ack_i = 1'b0;
      cnt = 0;
      prev_req = 1'b0;
    end else begin
      if (mem_req_o && prev_req && !mem_ack_i &&
          (mem_we_o !== prev_we || mem_addr_o !== prev_addr || mem_wdata_o !== prev_wdata))
        unstable = 1;
      prev_req = mem_req_o;
      prev_we = mem_we_o;
      prev_addr = mem_addr_o;
      prev_wdata = mem_wdata_o;
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        mem_rdata_i = {8{$urandom}};
        cnt = 0;
      end else if (mem_req_o) begin
        cnt++;
        if (cnt == lat + 1) begin
          mem_r.we = mem_we_o;
          mem_r.addr = mem_addr_o;
          mem_r.wdata = mem_wdata_o;
          req_log.push_back(mem_r);
          if (mem_we_o) offchip[mem_addr_o] = mem_wdata_o;
          else mem_rdata_i = offchip_line(mem_addr_o);
          mem_ack_i = 1'b1;
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mv[i] = 0;
      md[i] = 0;
    end
    flat.delete();
  endtask

  // Reference: the cache is transparent over flat memory; the directory predicts memory traffic.
  task automatic model_access(input logic [31:0] addr, input logic rd, input logic wr,
                              input logic [31:0] wdata, output logic [31:0] exp_rd,
                              output int exp_stall);
    int          idx;
    logic [21:0] tg;
    req_t        r;
    idx = int'(addr[9:5]);
    tg = addr[31:10];
    exp_q.delete();
    exp_stall = 0;
    exp_rd = '0;
    if (rd || wr) begin
      if (!(mv[idx] && mt[idx] == tg)) begin
        if (mv[idx] && md[idx]) begin
          r.we = 1'b1;
          r.addr = {mt[idx], addr[9:5], 5'b0};
          r.wdata = flat_line(r.addr);
          exp_q.push_back(r);
          exp_stall = 2 * lat + 4;
        end else begin
          exp_stall = lat + 2;
        end
        r.we = 1'b0;
        r.addr = {tg, addr[9:5], 5'b0};
        r.wdata = '0;
        exp_q.push_back(r);
        mv[idx] = 1;
        md[idx] = 0;
        mt[idx] = tg;
      end
      if (wr) begin
        flat[{addr[31:2], 2'b00}] = wdata;
        md[idx] = 1;
      end
      exp_rd = flat_word(addr);
    end
  endtask

  task automatic do_access(input logic [31:0] addr, input logic rd, input logic wr,
                           input logic [31:0] wdata, output logic [31:0] rdata, output int ncyc);
    @(negedge clk_i);
    cpu_addr_i = addr;
    cpu_rd_i = rd;
    cpu_wr_i = wr;
    cpu_wdata_i = wdata;
    #1;
    ncyc = 0;
    while (stall_o === 1'b1 && ncyc < BUDGET) begin
      @(negedge clk_i);
      #1;
      ncyc++;
    end
    rdata = cpu_rdata_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_req_o); end
    checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", mem_we_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr_o); end
    checks++; if (mem_wdata_o !== 256'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
  endtask

  task automatic test_cold_load();
    logic [31:0] rd, er;
    int n, es;
    lat = 4;
    req_log.delete();
    model_access(32'h40, 1'b1, 1'b0, '0, er, es);
    do_access(32'h40, 1'b1, 1'b0, '0, rd, n);
    checks++; if (n != 6) begin errors++; $display("FAIL cold_stall: got %0d cycles expected 6", n); end
    checks++; if (rd !== 32'hA0) begin errors++; $display("FAIL cold_rdata: got %h expected a0", rd); end
    checks++;
    if (req_log.size() != 1) begin
      errors++; $display("FAIL cold_req_count: got %0d expected 1", req_log.size());
    end else if (req_log[0].we !== 1'b0 || req_log[0].addr !== 32'h40) begin
      errors++; $display("FAIL cold_req: got we=%b addr=%h expected we=0 addr=00000040", req_log[0].we, req_log[0].addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, er;
    int n, es;
    lat = int'($urandom_range(0, 5));
    req_log.delete();
    model_access(32'h44, 1'b0, 1'b1, 32'hDEADBEEF, er, es);
    do_access(32'h44, 1'b0, 1'b1, 32'hDEADBEEF, rd, n);
    checks++; if (n != 0) begin errors++; $display("FAIL store_hit_stall: got %0d expected 0", n); end
    model_access(32'h44, 1'b1, 1'b0, '0, er, es);
    do_access(32'h44, 1'b1, 1'b0, '0, rd, n);
    checks++; if (n != 0) begin errors++; $display("FAIL load_hit_stall: got %0d expected 0", n); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_hit_rdata: got %h expected deadbeef", rd); end
    checks++; if (req_log.size() != 0) begin errors++; $display("FAIL hit_req_count: got %0d expected 0", req_log.size()); end
  endtask

  task automatic test_conflict_writeback();
    logic [31:0]  rd, er;
    logic [255:0] exp_line;
    int n, es;
    lat = int'($urandom_range(0, 5));
    for (int w = 0; w < 8; w++) exp_line[32*w +: 32] = 32'hA0 + 32'(w);
    exp_line[63:32] = 32'hDEADBEEF;
    req_log.delete();
    model_access(32'h440, 1'b1, 1'b0, '0, er, es);
    do_access(32'h440, 1'b1, 1'b0, '0, rd, n);
    checks++; if (n != 2 * lat + 4) begin errors++; $display("FAIL wb_stall: got %0d expected %0d", n, 2 * lat + 4); end
    checks++; if (rd !== init_word(32'h440)) begin errors++; $display("FAIL wb_rdata: got %h expected %h", rd, init_word(32'h440)); end
    checks++;
    if (req_log.size() != 2) begin
      errors++; $display("FAIL wb_req_count: got %0d expected 2", req_log.size());
    end else begin
      if (req_log[0].we !== 1'b1 || req_log[0].addr !== 32'h40 || req_log[0].wdata !== exp_line) begin
        errors++; $display("FAIL wb_victim: got we=%b addr=%h data=%h expected we=1 addr=00000040 data=%h",
                           req_log[0].we, req_log[0].addr, req_log[0].wdata, exp_line);
      end
      checks++;
      if (req_log[1].we !== 1'b0 || req_log[1].addr !== 32'h440) begin
        errors++; $display("FAIL wb_refill: got we=%b addr=%h expected we=0 addr=00000440", req_log[1].we, req_log[1].addr);
      end
    end
  endtask

  task automatic test_store_miss();
    logic [31:0]  rd, er, val;
    logic [255:0] exp_line;
    int n, es;
    lat = int'($urandom_range(0, 5));
    val = $urandom;
    req_log.delete();
    model_access(32'h80, 1'b0, 1'b1, val, er, es);
    do_access(32'h80, 1'b0, 1'b1, val, rd, n);
    checks++; if (n != lat + 2) begin errors++; $display("FAIL store_miss_stall: got %0d expected %0d", n, lat + 2); end
    checks++;
    if (req_log.size() != 1 || req_log[0].we !== 1'b0 || req_log[0].addr !== 32'h80) begin
      errors++; $display("FAIL store_miss_req: got count=%0d expected one read of 00000080", req_log.size());
    end
    model_access(32'h80, 1'b1, 1'b0, '0, er, es);
    do_access(32'h80, 1'b1, 1'b0, '0, rd, n);
    checks++; if (rd !== val || n != 0) begin errors++; $display("FAIL store_miss_merge: got %h/%0d expected %h/0", rd, n, val); end
    for (int w = 0; w < 8; w++) exp_line[32*w +: 32] = init_word(32'h80 + 32'(4*w));
    exp_line[31:0] = val;
    req_log.delete();
    model_access(32'h480, 1'b1, 1'b0, '0, er, es);
    do_access(32'h480, 1'b1, 1'b0, '0, rd, n);
    checks++;
    if (req_log.size() != 2 || req_log[0].we !== 1'b1 || req_log[0].addr !== 32'h80 || req_log[0].wdata !== exp_line) begin
      errors++; $display("FAIL store_miss_victim: got count=%0d data=%h expected writeback of 00000080 data=%h",
                         req_log.size(), req_log.size() > 0 ? req_log[0].wdata : 256'h0, exp_line);
    end
  endtask

  task automatic test_reset_mid_alloc();
    logic [31:0] rd, er;
    int n, es;
    lat = 8;
    req_log.delete();
    @(negedge clk_i);
    cpu_addr_i = 32'h1000;
    cpu_rd_i = 1'b1;
    cpu_wr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b expected 1", mem_req_o); end
    #1;
    rst_i = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b expected 0", mem_req_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b expected 0", stall_o); end
    @(negedge clk_i);
    cpu_rd_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
    checks++; if (req_log.size() != 0) begin errors++; $display("FAIL rst_abandon: got %0d acked requests expected 0", req_log.size()); end
    model_access(32'h1000, 1'b1, 1'b0, '0, er, es);
    do_access(32'h1000, 1'b1, 1'b0, '0, rd, n);
    checks++; if (n != lat + 2) begin errors++; $display("FAIL rst_remiss_stall: got %0d expected %0d", n, lat + 2); end
    checks++; if (rd !== er) begin errors++; $display("FAIL rst_remiss_rdata: got %h expected %h", rd, er); end
    checks++;
    if (req_log.size() != 1 || req_log[0].addr !== 32'h1000 || req_log[0].we !== 1'b0) begin
      errors++; $display("FAIL rst_remiss_req: got count=%0d expected one read of 00001000", req_log.size());
    end
  endtask

  task automatic test_no_access();
    req_log.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      cpu_addr_i = $urandom;
      cpu_wdata_i = $urandom;
      cpu_rd_i = 1'b0;
      cpu_wr_i = 1'b0;
      #1;
      checks++;
      if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
        errors++; $display("FAIL idle_cycle %0d: got stall=%b req=%b expected 0/0", i, stall_o, mem_req_o);
      end
    end
    @(negedge clk_i);
    checks++; if (req_log.size() != 0) begin errors++; $display("FAIL idle_req_count: got %0d expected 0", req_log.size()); end
  endtask

  task automatic test_random();
    logic [31:0] addr, wd, rd, er;
    logic        r, w;
    int          kind, n, es;
    for (int op = 0; op < 200; op++) begin
      if (op % 25 == 0) lat = int'($urandom_range(0, 5));
      kind = int'($urandom_range(0, 9));
      r = (kind >= 1 && kind <= 4) || kind == 9;
      w = kind >= 5;
      addr = {20'($urandom_range(0, 3)), 2'b00, 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom)};
      wd = $urandom;
      req_log.delete();
      model_access(addr, r, w, wd, er, es);
      do_access(addr, r, w, wd, rd, n);
      checks++; if (n != es) begin errors++; $display("FAIL rand_stall op %0d addr %h: got %0d expected %0d", op, addr, n, es); end
      if (r && !w) begin
        checks++; if (rd !== er) begin errors++; $display("FAIL rand_rdata op %0d addr %h: got %h expected %h", op, addr, rd, er); end
      end
      checks++;
      if (req_log.size() != exp_q.size()) begin
        errors++; $display("FAIL rand_req_count op %0d: got %0d expected %0d", op, req_log.size(), exp_q.size());
      end else begin
        foreach (exp_q[k]) begin
          if (req_log[k].we !== exp_q[k].we || req_log[k].addr !== exp_q[k].addr ||
              (exp_q[k].we && req_log[k].wdata !== exp_q[k].wdata)) begin
            errors++; $display("FAIL rand_req op %0d #%0d: got we=%b addr=%h expected we=%b addr=%h",
                               op, k, req_log[k].we, req_log[k].addr, exp_q[k].we, exp_q[k].addr);
          end
        end
      end
    end
    @(negedge clk_i);
    cpu_rd_i = 1'b0;
    cpu_wr_i = 1'b0;
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL mem_outputs_stable: got %b expected 0", unstable); end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_back_to_back();
    test_conflict_writeback();
    test_store_miss();
    test_reset_mid_alloc();
    test_no_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
